// File: rtl/i2s_rx.sv
// I2S slave receiver: deserialises a 2-channel ws/sdata stream into parallel
// left/right samples and pulses valid once per complete L/R pair.
module i2s_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             ws,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             valid,
    output logic             frame_err,
    output logic             locked
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {UNSYNC, RUN} state_t;

    state_t           r_state;
    logic             r_ws_d;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_left_hold;
    logic             r_have_left;

    logic             w_edge;
    logic             w_len_ok;
    logic [WIDTH-1:0] w_word;

    assign w_edge   = ws ^ r_ws_d;
    assign w_len_ok = (r_bit_cnt == CW'(WIDTH - 1));

    // Word as it stands after this sample: bit index bit_cnt lands MSB-first,
    // anything past WIDTH bits falls off the end.
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_bit_cnt == CW'(WIDTH - 1 - i))
                w_word[i] = sdata;
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state     <= UNSYNC;
            r_ws_d      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_have_left <= 1'b0;
            left_chan   <= '0;
            right_chan  <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            r_ws_d    <= ws;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (w_edge) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                if (r_state == UNSYNC) begin
                    // The word closing on the sync edge is partial; drop it.
                    r_state <= RUN;
                    locked  <= 1'b1;
                end else begin
                    frame_err <= ~w_len_ok;
                    if (!r_ws_d) begin
                        r_left_hold <= w_word;
                        r_have_left <= 1'b1;
                    end else if (r_have_left) begin
                        left_chan   <= r_left_hold;
                        right_chan  <= w_word;
                        valid       <= 1'b1;
                        r_have_left <= 1'b0;
                    end
                end
            end else begin
                r_shift <= w_word;
                if (r_bit_cnt != CW'(TIMEOUT))
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                // Losing ws edges for too long means the master stopped or we
                // slipped; outputs keep their last pair.
                if (r_state == RUN && r_bit_cnt >= CW'(TIMEOUT - 1)) begin
                    r_state     <= UNSYNC;
                    locked      <= 1'b0;
                    r_have_left <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver (slave) that deserialises a 2-channel I2S stream into parallel left/right samples.
- sclk and ws are supplied by the external I2S master.
- A one-cycle valid strobe marks each complete L/R pair.
- Sits at the audio input of the FPGA design and feeds DSP logic in the sclk domain.
- Standard I2S framing: ws=0 left, ws=1 right; MSB-first; MSB one sclk after each ws transition.

Parameters:
- WIDTH, 16, sample width in bits per channel.
- TIMEOUT, 255, max sclk cycles without a ws transition before sync is dropped (must be > 2*WIDTH, < 256).

Ports:
- sclk  input  1  serial bit clock. All logic runs on posedge; the transmitter drives on negedge.
- rst  input  1  reset, asynchronous, active-low.
- ws  input  1  word select from master.
- sdata  input  1  serial data.
- left_chan  output  WIDTH  last complete left sample.
- right_chan  output  WIDTH  last complete right sample.
- valid  output  1  one-cycle pulse: left_chan/right_chan updated with a new pair.
- frame_err  output  1  one-cycle pulse: the word just closed had length != WIDTH.
- locked  output  1  high while the receiver is synchronised to ws edges.

Behaviour:
- Reset (rst=0, async, immediate): left_chan=0, right_chan=0, valid=0, frame_err=0, locked=0, state=UNSYNC, ws_d=0, bit_cnt=0, shift_reg=0, left_hold=0, have_left=0.
- Every posedge samples ws and sdata. ws_d holds the previous sampled ws.
- edge = (ws != ws_d), evaluated on the current sample.
- Word boundary: on an edge posedge, the sdata sampled is the LSB of the word for channel ws_d. The next posedge samples the MSB of the new word.
- bit_cnt: cleared to 0 on edge; otherwise incremented, saturating at TIMEOUT. Word length at edge = bit_cnt+1.
- Capture: each posedge with idx=bit_cnt, if idx<WIDTH write sdata into bit WIDTH-1-idx of the assembled word (MSB-justified).
  - Bits with idx>=WIDTH are discarded (truncation).
  - Unwritten low bits of short words are 0 (zero-pad).
  - shift_reg is cleared on edge, after the completed word is taken.
- States:
  - UNSYNC: no words are delivered. On the first edge go to RUN and set locked=1; the word closing on that edge is discarded (partial).
  - RUN, on edge with ws_d=0 (left closed): left_hold <= word, have_left <= 1.
  - RUN, on edge with ws_d=1 (right closed): if have_left, then left_chan <= left_hold, right_chan <= word, valid=1 next cycle, have_left <= 0. Otherwise discard silently; this covers a right word arriving first after sync.
  - RUN: on any edge where length != WIDTH, frame_err pulses one cycle. The word is still delivered per the truncate/pad rules.
  - RUN: if bit_cnt reaches TIMEOUT with no edge, go to UNSYNC, locked <= 0, have_left <= 0. Outputs hold their values.
- Latency: valid and the output registers update on the posedge that samples the right-channel LSB (ws 1->0 edge). valid is high for exactly that one cycle.
- valid and frame_err are never asserted in UNSYNC. Both may pulse in the same cycle.
- Simultaneous edge and timeout: the edge wins; bit_cnt clears and the state stays/enters RUN.
- left_chan and right_chan only ever change together with valid=1.

Test Plan:
- Reset, then continuous frames L=0xA5C3 R=0x1234 at 32 sclk/frame -> locked=1 at first ws edge; first valid at end of first full L+R; left_chan=0xA5C3, right_chan=0x1234; valid every 32 sclk; frame_err=0.
- Release reset mid-left word, then L=0x0001 R=0x8000 -> partial word discarded; first valid has left=0x0001, right=0x8000; no valid before that.
- Sync on a ws 0->1 edge so the first full word is right=0x5555, then L=0x1111 R=0x2222 -> 0x5555 is never output; first valid gives 0x1111/0x2222.
- Left word of 18 bits 0xFFFF followed by bits 1,0, right 16-bit 0x0F0F -> left_chan=0xFFFF, right_chan=0x0F0F; frame_err pulses at the left close; valid at the right close.
- Left word of 14 bits all 1, right 16-bit 0xABCD -> left_chan=0xFFFC, right_chan=0xABCD; frame_err pulse.
- Hold ws constant for 300 sclk after lock -> locked falls at bit_cnt=255, outputs hold; a later ws edge relocks. Assert rst=0 mid-word -> all outputs 0 immediately, without an sclk edge.
